// File: rtl/ar_br_cr_pkg.sv
// ar_br_cr_pkg: shared width, command indices (CR-writer priority clr > div > mul) and AR status helper
package ar_br_cr_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int CMD_LOAD = 0;
  localparam int CMD_CLR = 1;
  localparam int CMD_DIV = 2;
  localparam int CMD_MUL = 3;
  localparam int NUM_CMD = 4;
  typedef struct packed {
    logic neg;
    logic pos;
    logic zero;
  } status_t;
  function automatic status_t sign_status(input logic msb, input logic nonzero);
    return '{neg: msb, pos: !msb && nonzero, zero: !nonzero};
  endfunction
endpackage

// File: rtl/ar_br_cr_datapath_if.sv
// ar_br_cr_datapath_if: command strobes, operands and register/status returns between controller and datapath
interface ar_br_cr_datapath_if
  import ar_br_cr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic load_AR_BR;
  logic div_AR_T_CR;
  logic mul_BR_T_CR;
  logic clr_CR;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic [WIDTH-1:0] AR;
  logic [WIDTH-1:0] BR;
  logic [WIDTH:0] CR;
  logic AR_neg;
  logic AR_pos;
  logic AR_zero;
  logic cmd_ack;
  logic cmd_err;
  modport master(
    output load_AR_BR, div_AR_T_CR, mul_BR_T_CR, clr_CR, data_A, data_B,
    input AR, BR, CR, AR_neg, AR_pos, AR_zero, cmd_ack, cmd_err
  );
  modport slave(
    input load_AR_BR, div_AR_T_CR, mul_BR_T_CR, clr_CR, data_A, data_B,
    output AR, BR, CR, AR_neg, AR_pos, AR_zero, cmd_ack, cmd_err
  );
endinterface

// File: rtl/ar_br_cr_edge_det.sv
// ar_br_cr_edge_det: 1-bit rising-edge detector; history always tracks the level, so reset preloads it too
module ar_br_cr_edge_det (
  input  logic clk,
  input  logic d,
  output logic rise
);
  logic h;
  always_ff @(posedge clk) h <= d;
  assign rise = d & ~h;
endmodule

// File: rtl/ar_br_cr_datapath.sv
// ar_br_cr_datapath: AR/BR/CR registers executing edge-qualified commands; AR_BR_CR_CMD_CHECK_EN builds the collision flag
module ar_br_cr_datapath
  import ar_br_cr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic reset,
  ar_br_cr_datapath_if.slave bus
);
  logic [NUM_CMD-1:0] lvl, fire;
  logic [WIDTH-1:0] ar, br;
  logic [WIDTH:0] cr, cr_next;
  logic ack;
  status_t st;
  assign lvl[CMD_LOAD] = bus.load_AR_BR;
  assign lvl[CMD_CLR] = bus.clr_CR;
  assign lvl[CMD_DIV] = bus.div_AR_T_CR;
  assign lvl[CMD_MUL] = bus.mul_BR_T_CR;
  for (genvar i = 0; i < NUM_CMD; i++) begin : g_ed
    ar_br_cr_edge_det u_ed (.clk(clk), .d(lvl[i]), .rise(fire[i]));
  end
  // CR ops read the pre-load AR/BR, so a same-cycle load does not affect them
  always_comb
    cr_next = fire[CMD_CLR] ? '0 :
              fire[CMD_DIV] ? {{2{ar[WIDTH-1]}}, ar[WIDTH-1:1]} :
              fire[CMD_MUL] ? {br, 1'b0} : cr;
  always_ff @(posedge clk) begin
    if (reset) begin
      ar <= '0;
      br <= '0;
      cr <= '0;
      ack <= 1'b0;
    end else begin
      if (fire[CMD_LOAD]) begin
        ar <= bus.data_A;
        br <= bus.data_B;
      end
      cr <= cr_next;
      ack <= |fire;
    end
  end
  assign st = sign_status(ar[WIDTH-1], |ar);
  assign bus.AR = ar;
  assign bus.BR = br;
  assign bus.CR = cr;
  assign bus.AR_neg = st.neg;
  assign bus.AR_pos = st.pos;
  assign bus.AR_zero = st.zero;
  assign bus.cmd_ack = ack;
`ifdef AR_BR_CR_CMD_CHECK_EN
  logic err;
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((fire[CMD_CLR] & fire[CMD_DIV]) | (fire[CMD_CLR] & fire[CMD_MUL]) | (fire[CMD_DIV] & fire[CMD_MUL])) err <= 1'b1;
  end
  assign bus.cmd_err = err;
`else
  assign bus.cmd_err = 1'b0;
`endif
endmodule

// File: tb/tb_ar_br_cr_datapath.sv
// tb_ar_br_cr_datapath: directed and random commands checked against an integer model of the command semantics
module tb_ar_br_cr_datapath;
  localparam int W = 8;
  localparam logic [3:0] L = 4'b0001, C = 4'b0010, D = 4'b0100, M = 4'b1000, N = 4'b0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ar_br_cr_datapath_if #(.WIDTH(W)) bus ();
  ar_br_cr_datapath #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int errors = 0, checks = 0;
  int m_ar = 0, m_br = 0, m_cr = 0;
  logic m_ack = 1'b0, m_err = 1'b0;
  logic [3:0] m_prev = 4'b0;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic check_all();
    chk("AR", {24'b0, bus.AR}, {24'b0, m_ar[7:0]});
    chk("BR", {24'b0, bus.BR}, {24'b0, m_br[7:0]});
    chk("CR", {23'b0, bus.CR}, {23'b0, m_cr[8:0]});
    chk("AR_neg", {31'b0, bus.AR_neg}, {31'b0, m_ar < 0});
    chk("AR_pos", {31'b0, bus.AR_pos}, {31'b0, m_ar > 0});
    chk("AR_zero", {31'b0, bus.AR_zero}, {31'b0, m_ar == 0});
    chk("cmd_ack", {31'b0, bus.cmd_ack}, {31'b0, m_ack});
    chk("cmd_err", {31'b0, bus.cmd_err}, {31'b0, m_err});
  endtask
  // lv bits: {mul, div, clr, load}
  task automatic step(input logic [3:0] lv, input logic [7:0] a = 8'h00, input logic [7:0] b = 8'h00, input logic r = 1'b0);
    logic [3:0] f;
    bus.load_AR_BR = lv[0];
    bus.clr_CR = lv[1];
    bus.div_AR_T_CR = lv[2];
    bus.mul_BR_T_CR = lv[3];
    bus.data_A = a;
    bus.data_B = b;
    reset = r;
    @(posedge clk);
    f = lv & ~m_prev;
    if (r) begin
      m_ar = 0; m_br = 0; m_cr = 0; m_ack = 1'b0; m_err = 1'b0;
    end else begin
      if (f[1]) m_cr = 0;
      else if (f[2]) m_cr = (m_ar < 0 && m_ar % 2 != 0) ? m_ar / 2 - 1 : m_ar / 2;
      else if (f[3]) m_cr = m_br * 2;
      if (f[0]) begin
        m_ar = $signed(a);
        m_br = $signed(b);
      end
      m_ack = |f;
`ifdef AR_BR_CR_CMD_CHECK_EN
      if ((f[1] & f[2]) | (f[1] & f[3]) | (f[2] & f[3])) m_err = 1'b1;
`endif
    end
    m_prev = lv;
    #1 check_all();
  endtask
  initial begin
    step(N, 8'h00, 8'h00, 1'b1);
    step(N);
    chk("rst_zero", {31'b0, bus.AR_zero}, 32'd1);
    step(L, 8'hF9, 8'h05);
    step(N);
    chk("t1_neg", {31'b0, bus.AR_neg}, 32'd1);
    step(D);
    step(N);
    chk("t1_cr", {23'b0, bus.CR}, 32'h1FC);
    step(L, 8'h03, 8'h7F);
    step(N);
    step(M);
    step(N);
    chk("t2_cr", {23'b0, bus.CR}, 32'h0FE);
    step(L, 8'h03, 8'h80);
    step(N);
    step(M);
    step(N);
    chk("t2_cr_min", {23'b0, bus.CR}, 32'h100);
    chk("t2_pos", {31'b0, bus.AR_pos}, 32'd1);
    step(M);
    step(N);
    step(L, 8'h7F, 8'h7F);
    step(N);
    step(M);
    step(N);
    step(L, 8'h00, 8'h11);
    step(N);
    step(C);
    step(N);
    chk("t3_cr", {23'b0, bus.CR}, 32'h000);
    step(L, 8'h07, 8'h00);
    repeat (5) step(D);
    chk("t4_cr", {23'b0, bus.CR}, 32'h003);
    step(C);
    step(D);
    step(N);
    chk("t4_cr2", {23'b0, bus.CR}, 32'h003);
    step(D | M);
    step(N);
    step(N);
    step(L, 8'h04, 8'h09);
    step(N);
    step(L | D, 8'h10, 8'h01);
    step(N);
    chk("t6_cr", {23'b0, bus.CR}, 32'h002);
    chk("t6_ar", {24'b0, bus.AR}, 32'h010);
    step(L, 8'h33, 8'h44, 1'b1);
    step(L, 8'h33, 8'h44);
    step(L, 8'h55, 8'h66);
    step(N);
    chk("t6_noload", {24'b0, bus.AR}, 32'h000);
    repeat (500) step(4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 49) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
